// File: rtl/parallel_to_serial_params_pkg.sv
// Constants and helpers shared by both ends of the parallel-to-serial link:
// baud/parity encodings, receiver FSM states and the baud divisor.
package parallel_to_serial_params_pkg;

    localparam logic [1:0] BAUD_9600   = 2'd0;
    localparam logic [1:0] BAUD_19200  = 2'd1;
    localparam logic [1:0] BAUD_38400  = 2'd2;
    localparam logic [1:0] BAUD_115200 = 2'd3;

    localparam logic PARITY_DISABLED = 1'b0;
    localparam logic PARITY_ENABLED  = 1'b1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    // Clock cycles per bit minus one; the bit timer counts DIV..0.
    function automatic logic [15:0] baud_div(int clk_hz, bit [1:0] sel);
        int baud;
        case (sel)
            2'd0:    baud = 9600;
            2'd1:    baud = 19200;
            2'd2:    baud = 38400;
            default: baud = 115200;
        endcase
        return 16'(clk_hz / baud - 1);
    endfunction

endpackage

// File: rtl/serial_rx_bit_timer.sv
// Loadable bit-period down-counter: ticks for one cycle at zero and reloads
// the full divisor so subsequent ticks land one bit apart.
module serial_rx_bit_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [15:0] reload_val,
    output logic        tick
);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (cnt == '0) cnt <= reload_val;
            else           cnt <= cnt - 16'd1;
        end
    end

    assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Async serial receiver: start / DATA_W data bits LSB first / optional even
// parity / stop, sampled at mid-bit, delivered as a parallel byte with flags.
module serial_to_parallel_rx
    import parallel_to_serial_params_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        baud_sel,
    input  logic              parity_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              rx_busy
);

    localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [15:0] DIV_9600   = baud_div(CLK_FREQ_HZ, BAUD_9600);
    localparam logic [15:0] DIV_19200  = baud_div(CLK_FREQ_HZ, BAUD_19200);
    localparam logic [15:0] DIV_38400  = baud_div(CLK_FREQ_HZ, BAUD_38400);
    localparam logic [15:0] DIV_115200 = baud_div(CLK_FREQ_HZ, BAUD_115200);

    rx_state_e          state, state_n;
    logic               sync1, sync2, line_prev, fall;
    logic [15:0]        start_div, div_q;
    logic               par_en_q, par_bad;
    logic [DATA_W-1:0]  shreg;
    logic [BIDX_W-1:0]  bit_idx;
    logic               timer_load, tick;

    always_comb begin
        case (baud_sel)
            BAUD_9600:  start_div = DIV_9600;
            BAUD_19200: start_div = DIV_19200;
            BAUD_38400: start_div = DIV_38400;
            default:    start_div = DIV_115200;
        endcase
    end

    // line_prev follows the synced line in every state, so after a break the
    // receiver only re-arms once the line has actually returned high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= serial_in;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall = line_prev && !sync2;

    serial_rx_bit_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (state != IDLE),
        .load       (timer_load),
        .load_val   ({1'b0, start_div[15:1]}),
        .reload_val (div_q),
        .tick       (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        timer_load = 1'b0;
        case (state)
            IDLE:   if (fall) begin
                        state_n    = START;
                        timer_load = 1'b1;
                    end
            START:  if (tick) state_n = sync2 ? IDLE : DATA;
            DATA:   if (tick && bit_idx == BIDX_W'(DATA_W - 1))
                        state_n = par_en_q ? PARITY : STOP;
            PARITY: if (tick) state_n = STOP;
            STOP:   if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_bad    <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE && fall) begin
                div_q    <= start_div;
                par_en_q <= parity_en;
                par_bad  <= 1'b0;
                bit_idx  <= '0;
            end
            if (state == DATA && tick) begin
                shreg   <= {sync2, shreg[DATA_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == PARITY && tick)
                par_bad <= (^shreg) ^ sync2;
            if (state == STOP && tick) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= par_en_q && par_bad;
                frame_err  <= !sync2;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx at a 1.152 MHz clock.
module tb_serial_to_parallel_rx;
    import parallel_to_serial_params_pkg::*;

    localparam int CLK_HZ = 1_152_000;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] baud_sel = BAUD_115200;
    logic       parity_en = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, rx_busy;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    serial_to_parallel_rx #(.CLK_FREQ_HZ(CLK_HZ), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_sel   (baud_sel),
        .parity_en  (parity_en),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && rx_valid) obs_q.push_back('{rx_data, parity_err, frame_err});

    function automatic int bit_cycles(input logic [1:0] sel);
        case (sel)
            2'd0:    return CLK_HZ / 9600;
            2'd1:    return CLK_HZ / 19200;
            2'd2:    return CLK_HZ / 38400;
            default: return CLK_HZ / 115200;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int n);
        serial_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Bit timing fixed by bsel at frame start; baud_sel may be changed at toggle_at.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] bsel, input logic pen,
                              input logic pbit, input logic stop, input int toggle_at);
        int n;
        n = bit_cycles(bsel);
        baud_sel  = bsel;
        parity_en = pen;
        exp_q.push_back('{d, pen ? ((^d) ^ pbit) : 1'b0, ~stop});
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            if (i == toggle_at) baud_sel = BAUD_115200;
            drive_bit(d[i], n);
        end
        if (pen) drive_bit(pbit, n);
        drive_bit(stop, n);
    endtask

    task automatic wait_obs(input int budget, output bit ok);
        for (int i = 0; i < budget && obs_q.size() == 0; i++) @(negedge clk);
        ok = (obs_q.size() > 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {parity_err, frame_err}); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok; rec_t got, exp;
        send_frame(8'hA5, BAUD_115200, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 20);
        exp = exp_q.pop_front();
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic: no rx_valid, want %h", exp); end
        else begin
            got = obs_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL basic: got %h want %h", got, exp); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_single: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_parity();
        bit ok; rec_t got, exp;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h3C, BAUD_9600, PARITY_ENABLED, k[0], 1'b1, -1);
            drive_bit(1'b1, 60);
            exp = exp_q.pop_front();
            wait_obs(500, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL parity%0d: no rx_valid, want %h", k, exp); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL parity%0d: got %h want %h", k, got, exp); end
            end
        end
        parity_en = 1'b0;
    endtask

    task automatic test_frame_err();
        bit ok; rec_t got, exp;
        send_frame(8'h55, BAUD_38400, 1'b0, 1'b0, 1'b0, -1);
        exp = exp_q.pop_front();
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL frame_err: no rx_valid, want %h", exp); end
        else begin
            got = obs_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL frame_err: got %h want %h", got, exp); end
        end
        drive_bit(1'b0, 300);
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stuck_low: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL stuck_low_busy: got %b want 0", rx_busy); end
        drive_bit(1'b1, 60);
        send_frame(8'h12, BAUD_38400, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 30);
        exp = exp_q.pop_front();
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL after_break: no rx_valid, want %h", exp); end
        else begin
            got = obs_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL after_break: got %h want %h", got, exp); end
        end
    endtask

    task automatic test_glitch();
        baud_sel = BAUD_115200;
        drive_bit(1'b0, 3);
        serial_in = 1'b1;
        n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", rx_busy); end
        drive_bit(1'b1, 30);
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b want 0", rx_busy); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_abort();
        bit ok; rec_t got, exp;
        baud_sel = BAUD_115200;
        drive_bit(1'b0, 10);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 10);
        rst = 1'b1;
        #1;
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h want 00", rx_data); end
        n_cmp++; if ({rx_valid, parity_err, frame_err, rx_busy} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_flags: got %b want 0000", {rx_valid, parity_err, frame_err, rx_busy}); end
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 120);
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_valid: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
        send_frame(8'h81, BAUD_115200, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 20);
        exp = exp_q.pop_front();
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL abort_next: no rx_valid, want %h", exp); end
        else begin
            got = obs_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL abort_next: got %h want %h", got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; rec_t got, exp;
        send_frame(8'h96, BAUD_19200, 1'b0, 1'b0, 1'b1, 3);
        send_frame(8'h3A, BAUD_19200, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hC5, BAUD_19200, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 60);
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            wait_obs(200, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL b2b%0d: no rx_valid, want %h", k, exp); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL b2b%0d: got %h want %h", k, got, exp); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d pulses want 0", obs_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
